// File: rtl/painterengine_gpu_fifo_arbiter.sv
// painterengine_gpu_fifo_arbiter
// Round-robin burst arbiter that shares the write port of one painterengine_gpu_fifo
// among several GPU requesters. Each grant lasts up to PARAM_BURST_LENGTH beats.
// Optional feature: define PAINTERENGINE_GPU_FIFO_ARBITER_ALMOST_FULL_EN to make the
// almost-full flag gate both beat acceptance and new grants.

module painterengine_gpu_fifo_arbiter #(
    parameter int PARAM_DATA_WIDTH      = 32,
    parameter int PARAM_REQUESTER_COUNT = 4,
    parameter int PARAM_BURST_LENGTH    = 16,
    localparam int LP_INDEX_WIDTH       = $clog2(PARAM_REQUESTER_COUNT),
    localparam int LP_COUNT_WIDTH       = $clog2(PARAM_BURST_LENGTH) + 1
) (
    input  logic                                              i_wire_clock,
    input  logic                                              i_wire_resetn,
    input  logic [PARAM_REQUESTER_COUNT-1:0]                  i_wire_request,
    input  logic [PARAM_REQUESTER_COUNT-1:0]                  i_wire_valid,
    input  logic [PARAM_REQUESTER_COUNT*PARAM_DATA_WIDTH-1:0] i_wire_data,
    output logic [PARAM_REQUESTER_COUNT-1:0]                  o_wire_grant,
    output logic [PARAM_REQUESTER_COUNT-1:0]                  o_wire_ready,
    output logic [LP_INDEX_WIDTH-1:0]                         o_wire_grant_index,
    output logic                                              o_wire_busy,
    output logic                                              o_wire_fifo_write,
    output logic [PARAM_DATA_WIDTH-1:0]                       o_wire_fifo_data,
    input  logic                                              i_wire_fifo_full,
    input  logic                                              i_wire_fifo_almost_full
);

    typedef enum logic {
        STATE_IDLE  = 1'b0,
        STATE_BURST = 1'b1
    } state_t;

    localparam logic [LP_COUNT_WIDTH-1:0] LP_LAST_BEAT  = LP_COUNT_WIDTH'(PARAM_BURST_LENGTH - 1);
    localparam logic [LP_INDEX_WIDTH-1:0] LP_LAST_INDEX = LP_INDEX_WIDTH'(PARAM_REQUESTER_COUNT - 1);

    state_t                              r_state;
    logic [PARAM_REQUESTER_COUNT-1:0]    r_grant;
    logic [LP_INDEX_WIDTH-1:0]           r_grant_index;
    logic [LP_INDEX_WIDTH-1:0]           r_last_index;
    logic [LP_COUNT_WIDTH-1:0]           r_beat_count;

    state_t                              w_next_state;
    logic                                w_space;
    logic                                w_grant_allowed;
    logic                                w_found;
    logic [LP_INDEX_WIDTH-1:0]           w_winner;
    logic [PARAM_REQUESTER_COUNT-1:0]    w_ready;
    logic                                w_beat;
    logic                                w_grantee_request;

`ifdef PAINTERENGINE_GPU_FIFO_ARBITER_ALMOST_FULL_EN
    assign w_space         = !(i_wire_fifo_full | i_wire_fifo_almost_full);
    assign w_grant_allowed = !(i_wire_fifo_full | i_wire_fifo_almost_full);
`else
    logic w_unused_almost_full;
    assign w_unused_almost_full = i_wire_fifo_almost_full;
    assign w_space              = !i_wire_fifo_full;
    assign w_grant_allowed      = 1'b1;
`endif

    // Wraps last_index + offset back into 0..N-1; the sum never reaches 2N.
    function automatic logic [LP_INDEX_WIDTH-1:0] wrapIndex(input int value);
        if (value >= PARAM_REQUESTER_COUNT) begin
            return LP_INDEX_WIDTH'(value - PARAM_REQUESTER_COUNT);
        end
        return LP_INDEX_WIDTH'(value);
    endfunction

    // Ready only for the grantee, only while it still requests and the FIFO has room;
    // gated by reset so nothing is accepted in a reset cycle.
    assign w_ready           = r_grant & i_wire_request & {PARAM_REQUESTER_COUNT{w_space & i_wire_resetn}};
    assign w_beat            = |(w_ready & i_wire_valid);
    assign w_grantee_request = i_wire_request[r_grant_index];

    assign o_wire_ready       = w_ready;
    assign o_wire_grant       = r_grant;
    assign o_wire_grant_index = r_grant_index;
    assign o_wire_busy        = (r_state == STATE_BURST);
    assign o_wire_fifo_write  = w_beat;

    // Data is a straight pass-through of the grantee's slice while a burst is open.
    always_comb begin
        o_wire_fifo_data = '0;
        if (r_state == STATE_BURST && i_wire_resetn) begin
            o_wire_fifo_data = i_wire_data[int'(r_grant_index) * PARAM_DATA_WIDTH +: PARAM_DATA_WIDTH];
        end
    end

    // Round-robin search starting just after the last grantee.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 1; i <= PARAM_REQUESTER_COUNT; i++) begin
            if (!w_found && i_wire_request[wrapIndex(int'(r_last_index) + i)]) begin
                w_found  = 1'b1;
                w_winner = wrapIndex(int'(r_last_index) + i);
            end
        end
    end

    // Next-state decision: open a burst on any request, close on last beat or release.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            STATE_IDLE: begin
                if (w_found && w_grant_allowed) begin
                    w_next_state = STATE_BURST;
                end
            end
            STATE_BURST: begin
                if (!w_grantee_request || (w_beat && r_beat_count == LP_LAST_BEAT)) begin
                    w_next_state = STATE_IDLE;
                end
            end
            default: w_next_state = STATE_IDLE;
        endcase
    end

    // State, grant and beat-counter registers with synchronous active-low reset.
    always_ff @(posedge i_wire_clock) begin
        if (!i_wire_resetn) begin
            r_state       <= STATE_IDLE;
            r_grant       <= '0;
            r_grant_index <= '0;
            r_last_index  <= LP_LAST_INDEX;
            r_beat_count  <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                STATE_IDLE: begin
                    if (w_next_state == STATE_BURST) begin
                        r_grant       <= PARAM_REQUESTER_COUNT'(1) << w_winner;
                        r_grant_index <= w_winner;
                        r_last_index  <= w_winner;
                        r_beat_count  <= '0;
                    end
                end
                STATE_BURST: begin
                    if (w_beat) begin
                        r_beat_count <= r_beat_count + 1'b1;
                    end
                    if (w_next_state == STATE_IDLE) begin
                        r_grant <= '0;
                    end
                end
                default: r_grant <= '0;
            endcase
        end
    end

endmodule
